// File: rtl/keyboard_ps2_ctrl.sv
// keyboard_ps2_ctrl: PS/2 scan-set-2 receiver and decoder producing Hack key codes.
// Optional feature: define KEYBOARD_SHIFT_EN to track shift keys (lower-case letters, shifted digit symbols).
module keyboard_ps2_ctrl #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] out,
    output logic        key_valid,
    output logic        frame_err
);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    r_clk_s, r_dat_s;
    logic          r_clk_prev;
    state_t        r_state;
    logic [2:0]    r_bcnt;
    logic [7:0]    r_shift;
    logic          r_par_ok;
    logic [TW-1:0] r_tcnt;
    logic          r_ferr;
    logic          r_ext, r_brk, r_kv;
    logic [7:0]    r_out;
`ifdef KEYBOARD_SHIFT_EN
    logic          r_lsh, r_rsh;
`endif
    logic          w_fall, w_data, w_deliver;
    logic [7:0]    w_base, w_code;

    assign w_fall    = r_clk_prev & ~r_clk_s[1];
    assign w_data    = r_dat_s[1];
    assign w_deliver = w_fall && r_state == S_STOP && w_data && r_par_ok;
    assign out       = {8'd0, r_out};
    assign key_valid = r_kv;
    assign frame_err = r_ferr;

    // Two-flop synchronizers for the asynchronous PS/2 lines plus edge-history flop (idle high)
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_clk_s    <= 2'b11;
            r_dat_s    <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_s    <= {r_clk_s[0], ps2_clk};
            r_dat_s    <= {r_dat_s[0], ps2_data};
            r_clk_prev <= r_clk_s[1];
        end
    end

    // Frame FSM: start, 8 data bits LSB first, odd parity, stop; abandons a stalled frame on timeout
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_bcnt   <= 3'd0;
            r_shift  <= 8'd0;
            r_par_ok <= 1'b0;
            r_tcnt   <= '0;
            r_ferr   <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            r_tcnt <= (r_state == S_IDLE || w_fall) ? '0 : r_tcnt + 1'b1;
            if (r_state != S_IDLE && !w_fall && r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                r_state <= S_IDLE;
                r_bcnt  <= 3'd0;
                r_shift <= 8'd0;
                r_ferr  <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        r_bcnt <= 3'd0;
                        if (!w_data) r_state <= S_DATA;
                    end
                    S_DATA: begin
                        r_shift <= {w_data, r_shift[7:1]};
                        r_bcnt  <= r_bcnt + 3'd1;
                        if (r_bcnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par_ok <= ^{r_shift, w_data};
                        r_state  <= S_STOP;
                    end
                    default: begin
                        r_ferr  <= !(w_data && r_par_ok);
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Scan-set-2 to Hack base code lookup; ext-prefixed codes use the navigation table
    always_comb begin
        w_base = 8'd0;
        if (r_ext) begin
            case (r_shift)
                8'h6B: w_base = 8'd130;  8'h75: w_base = 8'd131;  8'h74: w_base = 8'd132;
                8'h72: w_base = 8'd133;  8'h6C: w_base = 8'd134;  8'h69: w_base = 8'd135;
                8'h7D: w_base = 8'd136;  8'h7A: w_base = 8'd137;  8'h70: w_base = 8'd138;
                8'h71: w_base = 8'd139;
                default: w_base = 8'd0;
            endcase
        end else begin
            case (r_shift)
                8'h1C: w_base = 8'd65;  8'h32: w_base = 8'd66;  8'h21: w_base = 8'd67;  8'h23: w_base = 8'd68;
                8'h24: w_base = 8'd69;  8'h2B: w_base = 8'd70;  8'h34: w_base = 8'd71;  8'h33: w_base = 8'd72;
                8'h43: w_base = 8'd73;  8'h3B: w_base = 8'd74;  8'h42: w_base = 8'd75;  8'h4B: w_base = 8'd76;
                8'h3A: w_base = 8'd77;  8'h31: w_base = 8'd78;  8'h44: w_base = 8'd79;  8'h4D: w_base = 8'd80;
                8'h15: w_base = 8'd81;  8'h2D: w_base = 8'd82;  8'h1B: w_base = 8'd83;  8'h2C: w_base = 8'd84;
                8'h3C: w_base = 8'd85;  8'h2A: w_base = 8'd86;  8'h1D: w_base = 8'd87;  8'h22: w_base = 8'd88;
                8'h35: w_base = 8'd89;  8'h1A: w_base = 8'd90;
                8'h45: w_base = 8'd48;  8'h16: w_base = 8'd49;  8'h1E: w_base = 8'd50;  8'h26: w_base = 8'd51;
                8'h25: w_base = 8'd52;  8'h2E: w_base = 8'd53;  8'h36: w_base = 8'd54;  8'h3D: w_base = 8'd55;
                8'h3E: w_base = 8'd56;  8'h46: w_base = 8'd57;
                8'h29: w_base = 8'd32;  8'h5A: w_base = 8'd128; 8'h66: w_base = 8'd129; 8'h76: w_base = 8'd140;
                8'h05: w_base = 8'd141; 8'h06: w_base = 8'd142; 8'h04: w_base = 8'd143; 8'h0C: w_base = 8'd144;
                8'h03: w_base = 8'd145; 8'h0B: w_base = 8'd146; 8'h83: w_base = 8'd147; 8'h0A: w_base = 8'd148;
                8'h01: w_base = 8'd149; 8'h09: w_base = 8'd150; 8'h78: w_base = 8'd151; 8'h07: w_base = 8'd152;
                default: w_base = 8'd0;
            endcase
        end
    end

    // Shift-dependent adjustment: lower-case letters when no shift held, symbols for shifted digits
    always_comb begin
        w_code = w_base;
`ifdef KEYBOARD_SHIFT_EN
        if (!(r_lsh || r_rsh) && w_base >= 8'd65 && w_base <= 8'd90) w_code = w_base + 8'd32;
        if (r_lsh || r_rsh) begin
            case (w_base)
                8'd48: w_code = 8'd41;  8'd49: w_code = 8'd33;  8'd50: w_code = 8'd64;  8'd51: w_code = 8'd35;
                8'd52: w_code = 8'd36;  8'd53: w_code = 8'd37;  8'd54: w_code = 8'd94;  8'd55: w_code = 8'd38;
                8'd56: w_code = 8'd42;  8'd57: w_code = 8'd40;
                default: w_code = w_base;
            endcase
        end
`endif
    end

    // Decoder: prefix flags, make/break handling, last-pressed-wins output with new-code pulse
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_out <= 8'd0;
            r_kv  <= 1'b0;
            r_ext <= 1'b0;
            r_brk <= 1'b0;
`ifdef KEYBOARD_SHIFT_EN
            r_lsh <= 1'b0;
            r_rsh <= 1'b0;
`endif
        end else begin
            r_kv <= 1'b0;
            if (w_deliver) begin
                if (r_shift == 8'hE0) r_ext <= 1'b1;
                else if (r_shift == 8'hF0) r_brk <= 1'b1;
                else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
`ifdef KEYBOARD_SHIFT_EN
                    if (!r_ext && r_shift == 8'h12) r_lsh <= !r_brk;
                    if (!r_ext && r_shift == 8'h59) r_rsh <= !r_brk;
`endif
                    if (w_code != 8'd0) begin
                        if (!r_brk) begin
                            r_out <= w_code;
                            r_kv  <= r_out != w_code;
                        end else if (r_out == w_code) r_out <= 8'd0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_keyboard_ps2_ctrl.sv
// tb_keyboard_ps2_ctrl: self-checking bench for keyboard_ps2_ctrl with a table-driven key model.
module tb_keyboard_ps2_ctrl;
    localparam int TO = 5000;
    localparam int HALF = 10;
`ifdef KEYBOARD_SHIFT_EN
    localparam int EXP_A = 97;
`else
    localparam int EXP_A = 65;
`endif

    logic clock = 1'b0, reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [15:0] out;
    logic key_valid, frame_err;
    int checks = 0, failures = 0, kv_cnt = 0, fe_cnt = 0;
    logic kv_q = 1'b0, fe_q = 1'b0;
    logic [15:0] out_q = 16'd0;

    logic [7:0] lt[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                           8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] dg[10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    logic [7:0] fk[12] = '{8'h05,8'h06,8'h04,8'h0C,8'h03,8'h0B,8'h83,8'h0A,8'h01,8'h09,8'h78,8'h07};
    logic [7:0] ek[10] = '{8'h6B,8'h75,8'h74,8'h72,8'h6C,8'h69,8'h7D,8'h7A,8'h70,8'h71};
    logic [7:0] m_base[256], m_ext[256];
    logic [7:0] pool[$];
    bit m_e, m_b, m_ls, m_rs;
    logic [15:0] m_out;
    string shdig = ")!@#$%^&*(";

    keyboard_ps2_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .out(out), .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    // Pulse monitor: key_valid/frame_err must be single-cycle; key_valid only with a new nonzero out
    always @(negedge clock) begin
        if (reset && key_valid === 1'b1) begin
            kv_cnt++;
            checks++;
            if (kv_q || out == out_q || out == 16'd0) begin
                failures++;
                $display("FAIL kv_pulse: out=%0d prev_out=%0d prev_kv=%0b, required one-cycle pulse with new nonzero out", out, out_q, kv_q);
            end
        end
        if (reset && key_valid === 1'b0 && out !== out_q && out != 16'd0 && out_q !== 16'bx) begin
            checks++;
            failures++;
            $display("FAIL kv_missing: out changed %0d->%0d, required key_valid=1", out_q, out);
        end
        if (reset && frame_err === 1'b1) begin
            fe_cnt++;
            checks++;
            if (fe_q) begin
                failures++;
                $display("FAIL fe_width: frame_err high on consecutive cycles, required 1-cycle pulse");
            end
        end
        kv_q  = key_valid;
        fe_q  = frame_err;
        out_q = out;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b ^ bad_par);
        send_bit(stop);
        wait_cyc(6);
    endtask

    task automatic model_reset();
        m_e = 0; m_b = 0; m_ls = 0; m_rs = 0; m_out = 16'd0;
    endtask

    // Reference model: prefixes set flags, the next key byte consumes them
    task automatic model_rx(input logic [7:0] b, output int exp_kv);
        logic [7:0] c;
        exp_kv = 0;
        if (b == 8'hE0) m_e = 1;
        else if (b == 8'hF0) m_b = 1;
        else begin
            c = m_e ? m_ext[b] : m_base[b];
`ifdef KEYBOARD_SHIFT_EN
            if (!(m_ls || m_rs) && c >= 65 && c <= 90) c = c + 8'd32;
            else if ((m_ls || m_rs) && c >= 48 && c <= 57) c = shdig[c - 48];
            if (!m_e && b == 8'h12) m_ls = !m_b;
            if (!m_e && b == 8'h59) m_rs = !m_b;
`endif
            if (c != 0) begin
                if (!m_b) begin
                    exp_kv = (m_out != {8'd0, c}) ? 1 : 0;
                    m_out = {8'd0, c};
                end else if (m_out == {8'd0, c}) m_out = 16'd0;
            end
            m_e = 0;
            m_b = 0;
        end
    endtask

    task automatic sendm(input logic [7:0] b, inout int kv_exp);
        int e;
        send_frame(b, 1'b0, 1'b1);
        model_rx(b, e);
        kv_exp += e;
    endtask

    task automatic build_tables();
        for (int i = 0; i < 256; i++) begin m_base[i] = 8'd0; m_ext[i] = 8'd0; end
        for (int i = 0; i < 26; i++) begin m_base[lt[i]] = 8'(65 + i); pool.push_back(lt[i]); end
        for (int i = 0; i < 10; i++) begin m_base[dg[i]] = 8'(48 + i); pool.push_back(dg[i]); end
        for (int i = 0; i < 12; i++) begin m_base[fk[i]] = 8'(141 + i); pool.push_back(fk[i]); end
        for (int i = 0; i < 10; i++) m_ext[ek[i]] = 8'(130 + i);
        m_base[8'h29] = 8'd32; m_base[8'h5A] = 8'd128; m_base[8'h66] = 8'd129; m_base[8'h76] = 8'd140;
        pool.push_back(8'h29); pool.push_back(8'h5A); pool.push_back(8'h66); pool.push_back(8'h76);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wait_cyc(5);
        checks += 3;
        if (out !== 16'd0) begin failures++; $display("FAIL reset_out: got %0d want 0", out); end
        if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_kv: got %b want 0", key_valid); end
        if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_fe: got %b want 0", frame_err); end
        reset = 1'b1;
        model_reset();
        wait_cyc(5);
    endtask

    task automatic test_make_break();
        int k0, e;
        e = 0; k0 = kv_cnt;
        sendm(8'h1C, e);
        checks += 3;
        if (out !== 16'(EXP_A)) begin failures++; $display("FAIL make_A: out=%0d want %0d", out, EXP_A); end
        if (kv_cnt - k0 != 1) begin failures++; $display("FAIL make_A_kv: pulses=%0d want 1", kv_cnt - k0); end
        if (out[15:8] !== 8'd0) begin failures++; $display("FAIL out_hi: got %h want 00", out[15:8]); end
        k0 = kv_cnt;
        sendm(8'hF0, e); sendm(8'h1C, e);
        checks += 2;
        if (out !== 16'd0) begin failures++; $display("FAIL break_A: out=%0d want 0", out); end
        if (kv_cnt != k0) begin failures++; $display("FAIL break_A_kv: pulses=%0d want 0", kv_cnt - k0); end
        sendm(8'h1C, e); sendm(8'hF0, e); sendm(8'h32, e);
        checks++;
        if (out !== 16'(EXP_A)) begin failures++; $display("FAIL break_other: out=%0d want %0d", out, EXP_A); end
        k0 = kv_cnt;
        sendm(8'hE0, e); sendm(8'h75, e);
        checks += 2;
        if (out !== 16'd131) begin failures++; $display("FAIL ext_up: out=%0d want 131", out); end
        if (kv_cnt - k0 != 1) begin failures++; $display("FAIL ext_up_kv: pulses=%0d want 1", kv_cnt - k0); end
        sendm(8'hE0, e); sendm(8'hF0, e); sendm(8'h75, e);
        checks++;
        if (out !== 16'd0) begin failures++; $display("FAIL ext_break: out=%0d want 0", out); end
    endtask

    task automatic test_frame_errors();
        int k0, f0, e;
        e = 0; k0 = kv_cnt;
        sendm(8'h45, e); sendm(8'h45, e);
        checks += 2;
        if (out !== 16'd48) begin failures++; $display("FAIL digit0: out=%0d want 48", out); end
        if (kv_cnt - k0 != 1) begin failures++; $display("FAIL typematic_kv: pulses=%0d want 1", kv_cnt - k0); end
        f0 = fe_cnt;
        send_frame(8'h1C, 1'b1, 1'b1);
        checks += 2;
        if (fe_cnt - f0 != 1) begin failures++; $display("FAIL parity_err: pulses=%0d want 1", fe_cnt - f0); end
        if (out !== 16'd48) begin failures++; $display("FAIL parity_out: out=%0d want 48", out); end
        send_frame(8'h1C, 1'b0, 1'b0);
        checks += 2;
        if (fe_cnt - f0 != 2) begin failures++; $display("FAIL stop_err: pulses=%0d want 2", fe_cnt - f0); end
        if (out !== 16'd48) begin failures++; $display("FAIL stop_out: out=%0d want 48", out); end
    endtask

    task automatic test_timeout();
        int f0, e;
        e = 0;
        sendm(8'hF0, e); sendm(8'h45, e);
        f0 = fe_cnt;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        wait_cyc(TO - 100);
        checks++;
        if (fe_cnt != f0) begin failures++; $display("FAIL timeout_early: pulses=%0d want 0", fe_cnt - f0); end
        wait_cyc(200);
        checks++;
        if (fe_cnt - f0 != 1) begin failures++; $display("FAIL timeout_err: pulses=%0d want 1", fe_cnt - f0); end
        sendm(8'h45, e);
        checks += 2;
        if (out !== 16'd48) begin failures++; $display("FAIL after_timeout: out=%0d want 48", out); end
        if (fe_cnt - f0 != 1) begin failures++; $display("FAIL after_timeout_fe: pulses=%0d want 1", fe_cnt - f0); end
    endtask

    task automatic test_reset_mid();
        int f0, e;
        e = 0;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i >= 2 && i <= 4);
        reset = 1'b0;
        wait_cyc(3);
        reset = 1'b1;
        model_reset();
        wait_cyc(3);
        checks++;
        if (out !== 16'd0) begin failures++; $display("FAIL midreset_out: out=%0d want 0", out); end
        f0 = fe_cnt;
        sendm(8'h29, e);
        checks += 2;
        if (out !== 16'd32) begin failures++; $display("FAIL space: out=%0d want 32", out); end
        if (fe_cnt != f0) begin failures++; $display("FAIL midreset_fe: pulses=%0d want 0", fe_cnt - f0); end
    endtask

    task automatic test_random();
        logic [7:0] seq[$];
        logic [7:0] k, last_k;
        int k0, e;
        last_k = 8'h1C;
        for (int n = 0; n < 40; n++) begin
            seq.delete();
            k = pool[$urandom_range(0, pool.size() - 1)];
            case ($urandom_range(0, 6))
                0: begin seq.push_back(k); last_k = k; end
                1: begin seq.push_back(8'hF0); seq.push_back(k); end
                2: begin seq.push_back(8'hE0); seq.push_back(ek[$urandom_range(0, 9)]); end
                3: begin seq.push_back(8'hE0); seq.push_back(8'hF0); seq.push_back(ek[$urandom_range(0, 9)]); end
                4: begin
                    k = 8'($urandom_range(0, 255));
                    if (k == 8'hE0 || k == 8'hF0) k = 8'h00;
                    seq.push_back(k);
                end
                5: begin
                    if ($urandom_range(0, 1) == 1) seq.push_back(8'hF0);
                    seq.push_back(($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59);
                end
                default: begin seq.push_back(8'hF0); seq.push_back(last_k); end
            endcase
            e = 0;
            k0 = kv_cnt;
            foreach (seq[i]) sendm(seq[i], e);
            checks += 2;
            if (out !== m_out) begin failures++; $display("FAIL rand_out[%0d]: out=%0d want %0d", n, out, m_out); end
            if (kv_cnt - k0 != e) begin failures++; $display("FAIL rand_kv[%0d]: pulses=%0d want %0d", n, kv_cnt - k0, e); end
        end
    endtask

    initial begin
        build_tables();
        model_reset();
        test_reset();
        test_make_break();
        test_frame_errors();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keyboard_ps2_ctrl.md
KEYBOARD_PS2_CTRL -- requirements
Module: keyboard_ps2_ctrl

Interface
REQ-001 SHALL provide parameter: TIMEOUT_CYCLES, 5000, clock cycles without a PS/2 clock falling edge before an in-progress frame is abandoned.
REQ-002 SHALL have ports, one per line:
  clock  input  1  system clock; all state changes on its rising edge
  reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of clock)
  ps2_clk  input  1  PS/2 device clock; asynchronous to clock
  ps2_data  input  1  PS/2 device data; asynchronous to clock
  out  output  16  Hack key code of the key currently held, 0 when none; feeds the Memory keyboard register (address 0x6000)
  key_valid  output  1  one-cycle pulse when out takes a new nonzero value
  frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error

Function
REQ-003 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers and detect ps2_clk falling edges on the synchronized signal.
REQ-004 SHALL run frame FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on detected falling edges.
REQ-005 IDLE: sampled data 0 = start bit -> DATA with bit count 0; sampled 1 -> stay in IDLE.
REQ-006 DATA: shift in 8 bits LSB first; after the 8th bit -> PARITY.
REQ-007 PARITY: SHALL check odd parity over the 8 data bits plus the parity bit; record the result; -> STOP.
REQ-008 STOP: sampled 1 and parity good -> deliver byte to decoder; otherwise discard byte and pulse frame_err; -> IDLE in all cases.
REQ-009 SHALL count cycles since the last falling edge while not in IDLE; at TIMEOUT_CYCLES -> IDLE, discard partial byte, pulse frame_err.
REQ-010 Decoder byte E0 SHALL set ext flag; F0 SHALL set brk flag; both flags SHALL clear after the next non-prefix byte.
REQ-011 Mapping (scan set 2 -> Hack): letters A-Z -> 65-90; digits 0-9 -> 48-57; 29 -> 32 (space); 5A -> 128; 66 -> 129; 76 -> 140; with ext: 6B -> 130, 75 -> 131, 74 -> 132, 72 -> 133, 6C -> 134, 69 -> 135, 7D -> 136, 7A -> 137, 70 -> 138, 71 -> 139; F1-F12 -> 141-152. All other codes are unmapped.
REQ-012 Make of a mapped key SHALL set out to its code on the cycle after the stop-bit edge is detected; key_valid pulses on that cycle unless out already held the same code (typematic repeat: no pulse).
REQ-013 Break of the key currently in out SHALL set out to 0; break of any other key SHALL leave out unchanged; key_valid does not pulse.
REQ-014 Unmapped makes or breaks SHALL leave out unchanged.
REQ-015 A new make while another key is held SHALL replace out (last-pressed wins).
REQ-016 out[15:8] SHALL always be 0.

Reset
REQ-017 While reset=0: FSM IDLE, bit count, shift register, timeout counter, ext/brk flags cleared; out=0, key_valid=0, frame_err=0.
REQ-018 Reset asserted mid-frame SHALL discard the frame; after release, decoding SHALL resume at the next start bit.

Configuration
REQ-019 Macro KEYBOARD_SHIFT_EN: when defined, SHALL track left/right shift (12, 59) make/break; letters map to 97-122 unshifted and 65-90 shifted; shifted digits 1-9,0 map to !@#$%^&*() ASCII; a shift break SHALL NOT clear out.
REQ-020 Without KEYBOARD_SHIFT_EN: no shift state; shift codes are unmapped; letters always map to 65-90.

Verification
REQ-021 Frame 1C (data LSB first, parity 0, stop 1) -> out=65 (97 with KEYBOARD_SHIFT_EN) one cycle after stop edge; key_valid pulse of exactly 1 cycle.
REQ-022 Then F0,1C -> out=0, no key_valid; then F0,32 (break of B, not held) with out=65 -> out stays 65.
REQ-023 E0,75 -> out=131; E0,F0,75 -> out=0.
REQ-024 Frame 1C with parity bit 1 -> frame_err 1-cycle pulse, out unchanged; frame with stop bit 0 -> same.
REQ-025 Start bit plus 3 data bits, then ps2_clk idle for TIMEOUT_CYCLES -> frame_err pulse; following valid frame 45 decodes -> out=48.
REQ-026 reset=0 after 5 data bits of frame 1C, release, then full frame 29 -> out=32, no frame_err.
